// File: rtl/gshare_spec_bpu.sv
// Gshare direction predictor with speculatively updated global history and
// checkpoint-based repair; the PHT is initialised by a sequential clear walk.
module gshare_spec_bpu #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned HLEN   = 8,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned OFFSET = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             pred_valid_i,
  output logic             pred_ready_o,
  input  logic [XLEN-1:0]  pred_pc_i,
  output logic             pred_taken_o,
  output logic [HLEN-1:0]  pred_hist_o,
  input  logic             res_valid_i,
  input  logic [XLEN-1:0]  res_pc_i,
  input  logic [HLEN-1:0]  res_hist_i,
  input  logic             res_taken_i,
  input  logic             res_mispred_i,
  output logic             busy_o
);

  localparam int unsigned     ROWS     = 2 ** HLEN;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((2 ** (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MIN  = '0;
  localparam logic [HLEN-1:0]  LAST_ROW = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [HLEN-1:0]   clr_idx_q, clr_idx_d;
  logic [HLEN-1:0]   hist_q, hist_d;
  logic [CNT_W-1:0]  pht [ROWS];

  logic              run_c;
  logic              mispred_c;
  logic              handshake_c;
  logic [HLEN-1:0]   idx_r_c;
  logic [HLEN-1:0]   idx_w_c;
  logic [CNT_W-1:0]  res_cnt_c;
  logic [CNT_W-1:0]  res_cnt_next_c;
  logic              pht_we_c;
  logic [HLEN-1:0]   pht_waddr_c;
  logic [CNT_W-1:0]  pht_wdata_c;
  logic              unused_pc_bits;

  assign run_c       = (state_q == ST_RUN);
  assign mispred_c   = res_valid_i & res_mispred_i;
  assign busy_o      = ~run_c;

  // Prediction path: pure read, masked whenever the request cannot be accepted.
  assign pred_ready_o = run_c & ~mispred_c & ~flush_i;
  assign idx_r_c      = hist_q ^ pred_pc_i[HLEN+OFFSET-1:OFFSET];
  assign pred_taken_o = pred_ready_o & pht[idx_r_c][CNT_W-1];
  assign pred_hist_o  = pred_ready_o ? hist_q : '0;
  assign handshake_c  = pred_valid_i & pred_ready_o;

  // Only the hashed PC bits matter; the rest are intentionally dropped.
  assign unused_pc_bits = ^{pred_pc_i, res_pc_i};

  assign idx_w_c   = res_hist_i ^ res_pc_i[HLEN+OFFSET-1:OFFSET];
  assign res_cnt_c = pht[idx_w_c];

  always_comb begin
    res_cnt_next_c = res_cnt_c;
    if (res_taken_i) begin
      if (res_cnt_c != CNT_MAX) res_cnt_next_c = res_cnt_c + CNT_W'(1);
    end else begin
      if (res_cnt_c != CNT_MIN) res_cnt_next_c = res_cnt_c - CNT_W'(1);
    end
  end

  // Single PHT write port shared by the clear walk and branch resolution.
  always_comb begin
    pht_we_c    = 1'b0;
    pht_waddr_c = clr_idx_q;
    pht_wdata_c = CNT_INIT;
    if (!run_c) begin
      pht_we_c = 1'b1;
    end else if (res_valid_i && !flush_i) begin
      pht_we_c    = 1'b1;
      pht_waddr_c = idx_w_c;
      pht_wdata_c = res_cnt_next_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pht_we_c) pht[pht_waddr_c] <= pht_wdata_c;
  end

  // Next-state: flush beats repair, repair beats speculative shift.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    hist_d    = hist_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + HLEN'(1);
        if (clr_idx_q == LAST_ROW) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mispred_c) begin
          hist_d = {res_hist_i[HLEN-2:0], res_taken_i};
        end else if (handshake_c) begin
          hist_d = {hist_q[HLEN-2:0], pred_taken_o};
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    if (flush_i) begin
      state_d   = ST_CLEAR;
      clr_idx_d = '0;
      hist_d    = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      hist_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      hist_q    <= hist_d;
    end
  end

endmodule
